// File: rtl/rv32_fetch_unit.sv
// RV32 instruction fetch stage: owns the PC, fetches one word at a time over a
// req/gnt/rvalid handshake and hands it to decode over valid/ready.
module rv32_fetch_unit #(
  parameter logic [31:0] PC_RESET    = 32'h8000_0000,
  parameter logic [31:0] ROM_LO_WORD = 32'h2000_0000,
  parameter logic [31:0] ROM_HI_WORD = 32'h2000_3FFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic        fault_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_word_s;
  logic        fetch_ok_s;

  assign pc_word_s  = {2'b00, pc_q[31:2]};
  assign fetch_ok_s = (pc_q[1:0] == 2'b00) &&
                      (pc_word_s >= ROM_LO_WORD) && (pc_word_s <= ROM_HI_WORD);

  // Request side depends only on state and PC, never on gnt/rvalid/ready.
  assign imem_req_o  = (state_q == ST_REQ) && fetch_ok_s;
  assign imem_addr_o = pc_word_s;

  assign valid_o       = valid_q;
  assign fault_o       = fault_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign pc4_o         = pc_q + 32'd4;
  assign fetch_count_o = fetch_count_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      ST_REQ: begin
        if (redirect_i) begin
          pc_d = redirect_pc_i;
          // A granted request still owes us a response that must be dropped.
          state_d = (fetch_ok_s && imem_gnt_i) ? ST_DRAIN : ST_REQ;
        end else if (!fetch_ok_s) begin
          state_d = ST_FAULT;
        end else if (imem_gnt_i) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          state_d = imem_rvalid_i ? ST_REQ : ST_DRAIN;
        end else if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          state_d = ST_REQ;
        end else if (ready_i) begin
          pc_d          = pc_q + 32'd4;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (redirect_i) begin
          pc_d = redirect_pc_i;
        end else begin
          pc_d = pc_q;
        end
        state_d = imem_rvalid_i ? ST_REQ : ST_DRAIN;
      end
      ST_FAULT: begin
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          state_d = ST_REQ;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase

    valid_d = (state_d == ST_HOLD) || (state_d == ST_FAULT);
    fault_d = (state_d == ST_FAULT);
    if (state_d == ST_FAULT) begin
      instr_d = 32'h0000_0000;
    end else begin
      instr_d = instr_d;
    end
  end

  // State, PC, counter and registered decode-side outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_REQ;
      pc_q          <= PC_RESET;
      instr_q       <= 32'h0000_0000;
      valid_q       <= 1'b0;
      fault_q       <= 1'b0;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      valid_q       <= valid_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Directed self-checking bench for rv32_fetch_unit; inputs are driven and
// outputs sampled on the falling edge, memory responses are hand-sequenced.
module tb_rv32_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic        fault_o;
  logic [31:0] fetch_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  rv32_fetch_unit dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc4_o         (pc4_o),
    .fault_o       (fault_o),
    .fetch_count_o (fetch_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic test_reset();
    rst_i = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0; ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    n_checks++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b want 0", fault_o); end
    n_checks++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", instr_o); end
    n_checks++; if (fetch_count_o !== 32'h0) begin n_fail++; $display("FAIL rst_count: got %h want 0", fetch_count_o); end
    n_checks++; if (pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_pc: got %h want 80000000", pc_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_first_fetch();
    n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL ff_req: got %b want 1", imem_req_o); end
    n_checks++; if (imem_addr_o !== 32'h2000_0000) begin n_fail++; $display("FAIL ff_addr: got %h want 20000000", imem_addr_o); end
    imem_gnt_i = 1'b1;
    @(negedge clk_i);
    imem_gnt_i = 1'b0;
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL ff_wait_req: got %b want 0", imem_req_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL ff_wait_valid: got %b want 0", valid_o); end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0093;
    @(negedge clk_i);
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL ff_valid: got %b want 1", valid_o); end
    n_checks++; if (instr_o !== 32'h0000_0093) begin n_fail++; $display("FAIL ff_instr: got %h want 00000093", instr_o); end
    n_checks++; if (pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL ff_pc: got %h want 80000000", pc_o); end
    n_checks++; if (pc4_o !== 32'h8000_0004) begin n_fail++; $display("FAIL ff_pc4: got %h want 80000004", pc4_o); end
    n_checks++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL ff_fault: got %b want 0", fault_o); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_checks++;
      if (valid_o !== 1'b1 || instr_o !== 32'h0000_0093 || pc_o !== 32'h8000_0000 || imem_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stable[%0d]: got valid=%b instr=%h pc=%h req=%b want 1/00000093/80000000/0",
                 i, valid_o, instr_o, pc_o, imem_req_o);
      end
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL bp_req: got %b want 1", imem_req_o); end
    n_checks++; if (imem_addr_o !== 32'h2000_0001) begin n_fail++; $display("FAIL bp_addr: got %h want 20000001", imem_addr_o); end
    n_checks++; if (fetch_count_o !== 32'd1) begin n_fail++; $display("FAIL bp_count: got %h want 1", fetch_count_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_valid: got %b want 0", valid_o); end
  endtask

  task automatic test_redirect_wait();
    imem_gnt_i = 1'b1;
    @(negedge clk_i);
    imem_gnt_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0100;
    @(negedge clk_i);
    redirect_i = 1'b0;
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rw_drain_req: got %b want 0", imem_req_o); end
    n_checks++; if (pc_o !== 32'h8000_0100) begin n_fail++; $display("FAIL rw_pc: got %h want 80000100", pc_o); end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rw_stale_valid: got %b instr=%h want valid 0", valid_o, instr_o); end
    n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL rw_req: got %b want 1", imem_req_o); end
    n_checks++; if (imem_addr_o !== 32'h2000_0040) begin n_fail++; $display("FAIL rw_addr: got %h want 20000040", imem_addr_o); end
    imem_gnt_i = 1'b1;
    @(negedge clk_i);
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0010_0113;
    @(negedge clk_i);
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    n_checks++; if (valid_o !== 1'b1 || instr_o !== 32'h0010_0113) begin n_fail++; $display("FAIL rw_fetch: got valid=%b instr=%h want 1/00100113", valid_o, instr_o); end
    n_checks++; if (pc_o !== 32'h8000_0100) begin n_fail++; $display("FAIL rw_fetch_pc: got %h want 80000100", pc_o); end
  endtask

  task automatic test_redirect_ready_hold();
    ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0020;
    @(negedge clk_i);
    ready_i = 1'b0; redirect_i = 1'b0;
    n_checks++; if (pc_o !== 32'h8000_0020) begin n_fail++; $display("FAIL rh_pc: got %h want 80000020", pc_o); end
    n_checks++; if (fetch_count_o !== 32'd1) begin n_fail++; $display("FAIL rh_count: got %h want 1", fetch_count_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rh_valid: got %b want 0", valid_o); end
    n_checks++; if (imem_addr_o !== 32'h2000_0008) begin n_fail++; $display("FAIL rh_addr: got %h want 20000008", imem_addr_o); end
  endtask

  task automatic test_faults();
    redirect_i = 1'b1; redirect_pc_i = 32'h8001_0000;
    @(negedge clk_i);
    redirect_i = 1'b0;
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL fo_req: got %b want 0", imem_req_o); end
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_checks++;
      if (valid_o !== 1'b1 || fault_o !== 1'b1 || instr_o !== 32'h0 || imem_req_o !== 1'b0 || fetch_count_o !== 32'd1) begin
        n_fail++;
        $display("FAIL fo_fault[%0d]: got valid=%b fault=%b instr=%h req=%b cnt=%h want 1/1/0/0/1",
                 i, valid_o, fault_o, instr_o, imem_req_o, fetch_count_o);
      end
    end
    ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0000;
    @(negedge clk_i);
    redirect_i = 1'b0;
    n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h2000_0000) begin n_fail++; $display("FAIL fo_resume: got req=%b addr=%h want 1/20000000", imem_req_o, imem_addr_o); end
    n_checks++; if (valid_o !== 1'b0 || fault_o !== 1'b0) begin n_fail++; $display("FAIL fo_clear: got valid=%b fault=%b want 0/0", valid_o, fault_o); end
    imem_gnt_i = 1'b1;
    @(negedge clk_i);
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013;
    @(negedge clk_i);
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    n_checks++; if (valid_o !== 1'b1 || fault_o !== 1'b0 || instr_o !== 32'h0000_0013) begin n_fail++; $display("FAIL fo_refetch: got valid=%b fault=%b instr=%h want 1/0/00000013", valid_o, fault_o, instr_o); end
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    n_checks++; if (fetch_count_o !== 32'd2) begin n_fail++; $display("FAIL fo_count: got %h want 2", fetch_count_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0002;
    @(negedge clk_i);
    redirect_i = 1'b0;
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL fo_mis_req: got %b want 0", imem_req_o); end
    @(negedge clk_i);
    n_checks++; if (fault_o !== 1'b1 || valid_o !== 1'b1) begin n_fail++; $display("FAIL fo_mis_fault: got fault=%b valid=%b want 1/1", fault_o, valid_o); end
    // Top word of the ROM window is still a legal fetch.
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_FFFC;
    @(negedge clk_i);
    redirect_i = 1'b0;
    n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h2000_3FFF) begin n_fail++; $display("FAIL fo_hi_edge: got req=%b addr=%h want 1/20003fff", imem_req_o, imem_addr_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0004;
    @(negedge clk_i);
    redirect_i = 1'b0;
  endtask

  task automatic test_counter_wrap();
    imem_gnt_i = 1'b1;
    @(negedge clk_i);
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0020_0193;
    @(negedge clk_i);
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    @(negedge clk_i);
    release dut.fetch_count_q;
    n_checks++; if (fetch_count_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cw_preload: got %h want ffffffff", fetch_count_o); end
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    n_checks++; if (fetch_count_o !== 32'h0) begin n_fail++; $display("FAIL cw_wrap: got %h want 0", fetch_count_o); end
    n_checks++; if (imem_addr_o !== 32'h2000_0002) begin n_fail++; $display("FAIL cw_addr: got %h want 20000002", imem_addr_o); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ready_hold();
    test_faults();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
